data_memory_lsu: RTL
====================

// Module: data_memory_lsu
// PURPOSE
//  Parametrised, pipelined data memory for the RISC-V datapath: word-organised RAM with byte/half/word
//  loads and stores, sign/zero extension, misalign and range error detection.
//  Uses a valid/ready request port and returns a fixed-latency response.
//  Post-reset clear FSM zeroes the array. Sits between the ALU address path and the writeback mux.
// PARAMETERS
//  ADDR_W          32    byte-address width
//  DEPTH_WORDS     1024  number of 32-bit words (power of 2, >=4)
//  LATENCY         1     accept-to-response cycles, legal 1..4
//  CLEAR_ON_RESET  1     1: zero the whole array after every reset; 0: contents retained
// PORTS
//  clk          in   1       rising-edge clock
//  reset_n      in   1       asynchronous, active-low reset
//  req_valid    in   1       request present
//  req_ready    out  1       block accepts a request this cycle
//  req_write    in   1       1 store, 0 load
//  req_size     in   2       0 byte, 1 half, 2 word, 3 illegal
//  req_unsigned in   1       load zero-extends (LBU/LHU); ignored for word and stores
//  req_addr     in   ADDR_W  byte address
//  req_wdata    in   32      store data, LSB-aligned
//  rsp_valid    out  1       one-cycle response pulse
//  rsp_rdata    out  32      extended load data; 0 for stores and errors
//  rsp_err      out  1       misaligned / out-of-range / illegal-size request
//  init_done    out  1       clear sweep finished, block usable
// BEHAVIOUR
//  Reset (reset_n low, async): state=IDLE, clr_idx=0, all pipeline valids=0; rsp_valid=0, rsp_rdata=0,
//   rsp_err=0, req_ready=0, init_done=0. Array contents are not reset asynchronously.
//  FSM: IDLE -> CLEAR (CLEAR_ON_RESET=1) or RUN (=0) on first clk after release.
//   CLEAR: write 0 to word clr_idx, clr_idx++ each cycle; leave for RUN after word DEPTH_WORDS-1,
//   so CLEAR lasts exactly DEPTH_WORDS cycles. RUN is terminal until the next reset.
//  req_ready = (state==RUN); init_done = (state==RUN). Accept = req_valid & req_ready at posedge.
//  Throughput is one request per cycle. There is no response backpressure.
//  Decode: idx = req_addr[ADDR_W-1:2], off = req_addr[1:0].
//   err if size==3, or half with off[0]=1, or word with off!=0, or idx>=DEPTH_WORDS.
//  Store (no err): writes on the accept edge, little-endian byte lanes.
//   SB: lane off <= wdata[7:0]. SH: lanes off,off+1 <= wdata[15:0]. SW: all lanes.
//   Other lanes are untouched. An errored store writes nothing.
//  Load: reads array word idx at the accept edge. Selects the byte/half at off.
//   Sign-extends from bit 7/15 unless req_unsigned. Word loads pass through.
//  Response: exactly LATENCY cycles after the accept edge, rsp_valid=1 for one cycle with rdata/err.
//   Every accepted request (load, store, error) gets exactly one response, in acceptance order.
//   Outputs are 0 when rsp_valid=0.
//  Read-after-write: a load accepted on the cycle after a store to the same word returns the new data.
//   Back-to-back is the closest spacing, because only one request is accepted per cycle.
//  Reset mid-operation: in-flight responses are discarded (no rsp_valid after reset).
//   A store accepted on the same edge that reset asserts is not guaranteed.
//   CLEAR reruns from word 0 even if a previous sweep was partial.
//  clr_idx is $clog2(DEPTH_WORDS) bits wide and wraps to 0 on exit. It is unused in RUN.
// TESTING
//  T1 reset release, DEPTH_WORDS=16, CLEAR_ON_RESET=1
//     -> req_ready/init_done low for 1+16 cycles, then high; LW of every word returns 0.
//  T2 SW 0x8 data 0xDEADBEEF; LB 0x9 -> 0xFFFFFFBE; LBU 0x9 -> 0x000000BE; LH 0xA -> 0xFFFFDEAD;
//     LHU 0xA -> 0x0000DEAD; responses exactly LATENCY cycles after each accept.
//  T3 SW 0x0 data 0x11223344, SB 0x2 data 0xAA, SH 0x0 data 0x5566 issued back-to-back,
//     then LW 0x0 -> 0x11AA5566.
//  T4 LH 0x3, SW 0x6, size=3, LW at DEPTH_WORDS*4 -> each rsp_err=1 with rdata 0;
//     LW 0x4 afterwards shows no write happened.
//  T5 LATENCY=3: 8 loads on consecutive cycles -> 8 in-order rsp_valid pulses on consecutive cycles;
//     assert reset_n with 2 still in flight -> no further rsp_valid.
//  T6 CLEAR_ON_RESET=0: SW 0x10 data 0xCAFEF00D, reset pulse -> ready 1 cycle after release;
//     LW 0x10 -> 0xCAFEF00D.

Source files
------------

// File: rtl/data_memory_lsu_if.sv
`default_nettype none
// ============================================================================
//  Module      : data_memory_lsu_if
//  Description : Request/response bundle between the LSU master and the data memory.
//  Revision    : 1.0  initial release
// ============================================================================
interface data_memory_lsu_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              init_done;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
  );
endinterface
`default_nettype wire

// File: rtl/data_memory_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : data_memory_lsu
//  Description : Word-organised data RAM with byte/half/word access, extension,
//                error detection, fixed-latency response and post-reset clear.
//  Revision    : 1.0  initial release
// ============================================================================
module data_memory_lsu #(
  parameter int ADDR_W         = 32,
  parameter int DEPTH_WORDS    = 1024,
  parameter int LATENCY        = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input wire               clk,
  input wire               reset_n,
  data_memory_lsu_if.slave bus
);

  localparam int                 c_IDX_W      = $clog2(DEPTH_WORDS);
  localparam int                 c_LAST_STAGE = LATENCY - 1;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX   = c_IDX_W'(DEPTH_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_IDX_W-1:0] r_clr_idx;
  logic [c_IDX_W-1:0] w_clr_idx_nxt;

  logic [31:0] r_mem [DEPTH_WORDS];

  // ---------------------------------------------------------------- control FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_clr_idx <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_idx <= w_clr_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_idx_nxt = r_clr_idx;
    case (r_state)
      ST_IDLE: w_state_nxt = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      ST_CLEAR: begin
        // Index wraps naturally to 0 as the last word is written.
        w_clr_idx_nxt = r_clr_idx + 1'b1;
        if (r_clr_idx == c_LAST_IDX) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  logic w_ready;
  logic w_accept;

  assign w_ready       = (r_state == ST_RUN);
  assign w_accept      = bus.req_valid & w_ready;
  assign bus.req_ready = w_ready;
  assign bus.init_done = w_ready;

  // ---------------------------------------------------------------- decode
  logic [ADDR_W-3:0]  w_word_addr;
  logic [1:0]         w_off;
  logic [c_IDX_W-1:0] w_idx;
  logic               w_oor;
  logic               w_misalign;
  logic               w_err;

  assign w_word_addr = bus.req_addr[ADDR_W-1:2];
  assign w_off       = bus.req_addr[1:0];
  assign w_idx       = w_word_addr[c_IDX_W-1:0];
  assign w_oor       = ({1'b0, w_word_addr} >= (ADDR_W-1)'(DEPTH_WORDS));

  always_comb begin
    w_misalign = 1'b0;
    case (bus.req_size)
      2'd1:    w_misalign = w_off[0];
      2'd2:    w_misalign = (w_off != 2'd0);
      2'd3:    w_misalign = 1'b1;
      default: w_misalign = 1'b0;
    endcase
  end

  assign w_err = w_misalign | w_oor;

  // ---------------------------------------------------------------- store lanes
  logic [3:0]  w_st_be;
  logic [31:0] w_st_data;

  always_comb begin
    w_st_be   = 4'b0000;
    w_st_data = bus.req_wdata;
    case (bus.req_size)
      2'd0: begin
        w_st_be   = 4'b0001 << w_off;
        w_st_data = {4{bus.req_wdata[7:0]}};
      end
      2'd1: begin
        w_st_be   = w_off[1] ? 4'b1100 : 4'b0011;
        w_st_data = {2{bus.req_wdata[15:0]}};
      end
      2'd2:    w_st_be = 4'b1111;
      default: w_st_be = 4'b0000;
    endcase
  end

  // Single write port shared by the clear sweep and stores; they never overlap.
  logic [3:0]         w_mem_we;
  logic [c_IDX_W-1:0] w_mem_idx;
  logic [31:0]        w_mem_wdata;

  always_comb begin
    w_mem_we    = 4'b0000;
    w_mem_idx   = w_idx;
    w_mem_wdata = w_st_data;
    if (r_state == ST_CLEAR) begin
      w_mem_we    = 4'b1111;
      w_mem_idx   = r_clr_idx;
      w_mem_wdata = '0;
    end else if (w_accept && bus.req_write && !w_err) begin
      w_mem_we = w_st_be;
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (w_mem_we[b]) begin
        r_mem[w_mem_idx][8*b +: 8] <= w_mem_wdata[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------- response pipeline
  logic        r_vld  [LATENCY];
  logic        r_err  [LATENCY];
  logic        r_wr   [LATENCY];
  logic        r_uns  [LATENCY];
  logic [1:0]  r_size [LATENCY];
  logic [1:0]  r_off  [LATENCY];
  logic [31:0] r_word [LATENCY];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < LATENCY; s++) begin
        r_vld[s] <= 1'b0;
      end
    end else begin
      r_vld[0] <= w_accept;
      for (int s = 1; s < LATENCY; s++) begin
        r_vld[s] <= r_vld[s-1];
      end
    end
  end

  // Payload needs no reset: every output is gated by the valid chain.
  always_ff @(posedge clk) begin
    r_err[0]  <= w_err;
    r_wr[0]   <= bus.req_write;
    r_uns[0]  <= bus.req_unsigned;
    r_size[0] <= bus.req_size;
    r_off[0]  <= w_off;
    r_word[0] <= r_mem[w_idx];
    for (int s = 1; s < LATENCY; s++) begin
      r_err[s]  <= r_err[s-1];
      r_wr[s]   <= r_wr[s-1];
      r_uns[s]  <= r_uns[s-1];
      r_size[s] <= r_size[s-1];
      r_off[s]  <= r_off[s-1];
      r_word[s] <= r_word[s-1];
    end
  end

  logic [31:0] w_out_word;
  logic [7:0]  w_sel_byte;
  logic [15:0] w_sel_half;
  logic [31:0] w_ext;
  logic        w_out_vld;

  assign w_out_word = r_word[c_LAST_STAGE];
  assign w_out_vld  = r_vld[c_LAST_STAGE];

  always_comb begin
    w_sel_byte = w_out_word[{r_off[c_LAST_STAGE], 3'b000} +: 8];
    w_sel_half = r_off[c_LAST_STAGE][1] ? w_out_word[31:16] : w_out_word[15:0];
    case (r_size[c_LAST_STAGE])
      2'd0:    w_ext = {{24{w_sel_byte[7] & ~r_uns[c_LAST_STAGE]}}, w_sel_byte};
      2'd1:    w_ext = {{16{w_sel_half[15] & ~r_uns[c_LAST_STAGE]}}, w_sel_half};
      default: w_ext = w_out_word;
    endcase
  end

  assign bus.rsp_valid = w_out_vld;
  assign bus.rsp_err   = w_out_vld & r_err[c_LAST_STAGE];
  assign bus.rsp_rdata = (w_out_vld && !r_err[c_LAST_STAGE] && !r_wr[c_LAST_STAGE]) ? w_ext : 32'd0;

endmodule
`default_nettype wire
